cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter that generalises the fixed one-source-per-bus CDB pairing of the Tomasulo core.
- NUM_SRC functional units (adder, load unit, branch unit, future multiplier) each push results into a private FIFO.
- Each cycle the block broadcasts up to NUM_BUS results on NUM_BUS registered buses, using round-robin fairness.
- Reservation stations and the reorder buffer snoop the buses; a ROB flush (misprediction or exception) discards all pending results.

Parameters:
NUM_SRC, 4, number of producing functional units (2..2**SRC_W)
NUM_BUS, 2, number of broadcast buses (1..NUM_SRC)
DATA_W, 32, result data width
ROB_W, 3, reorder-buffer index width
SRC_W, 2, width of a source identifier
FIFO_DEPTH, 2, entries per source FIFO (power of two, >=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
flush  in  1  synchronous ROB flush; discards all buffered and in-flight results
src_valid  in  NUM_SRC  per-source result valid
src_ready  out  NUM_SRC  per-source FIFO not full
src_robNum  in  NUM_SRC*ROB_W  per-source ROB tag, source i at bits [i*ROB_W +: ROB_W]
src_data  in  NUM_SRC*DATA_W  per-source result, same packing
bus_iscast  out  NUM_BUS  bus b carries a valid broadcast this cycle
bus_robNum  out  NUM_BUS*ROB_W  broadcast ROB tag per bus
bus_data  out  NUM_BUS*DATA_W  broadcast value per bus
bus_src  out  NUM_BUS*SRC_W  source id granted on each bus (debug/perf)
pending  out  NUM_SRC*($clog2(FIFO_DEPTH)+1)  per-source FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs empty, rr_ptr=0; bus_iscast, bus_robNum, bus_data, bus_src all 0; src_ready all 1; pending all 0.
- src_ready[i] = (count[i] < FIFO_DEPTH), derived from registered count only. No same-cycle pop pass-through: a full FIFO stays not-ready even when popped that cycle.
- Push: src_valid[i] & src_ready[i] at a rising edge writes {robNum, data} at the tail. src_valid while not ready is ignored (the source must hold and retry).
- Arbitration (combinational on registered FIFO state):
  - Scan sources (rr_ptr, rr_ptr+1, ..., rr_ptr+NUM_SRC-1) mod NUM_SRC.
  - The first NUM_BUS non-empty FIFOs win. The k-th winner goes to bus k.
  - Each source gets at most one grant per cycle. Winners pop their head at the edge.
- Buses are registered:
  - At the edge, bus k loads the winner's head; bus_iscast[k]=1.
  - Unused buses load iscast=0, robNum=0, data=0.
  - Minimum latency src_valid accepted at edge T -> on bus after edge T+1.
- rr_ptr update: if at least one grant, rr_ptr <= (last granted source + 1) mod NUM_SRC; otherwise unchanged.
- Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
- Occupancy and pointers:
  - pending[i] reflects count after the edge.
  - Head/tail pointers wrap modulo FIFO_DEPTH.
  - Count never exceeds FIFO_DEPTH and never underflows.
- Flush (flush=1 at an edge):
  - All FIFOs emptied; all bus_iscast cleared to 0 with robNum/data 0; rr_ptr <= 0.
  - Pushes in that cycle are dropped.
  - The next cycle's buses are idle.
  - Flush has priority over push, pop, and arbitration.
- Reset asserted mid-operation: immediate (asynchronous) clear, no partial broadcast.
- No result is ever broadcast twice, and no accepted result is lost except by flush or reset.

Test Plan:
1. Reset then single push: source 2 pushes robNum=5, data=0x1234 at edge 1 -> after edge 2, bus_iscast=01, bus_robNum[0]=5, bus_data[0]=0x1234, bus_src[0]=2; all buses idle after edge 3.
2. All 4 sources push every cycle with NUM_BUS=2 for 4 cycles:
   - Grants alternate {0,1},{2,3},{0,1},...
   - src_ready deasserts when count=2.
   - Every tag appears exactly once, in per-source FIFO order.
3. FIFO full: source 0 pushes 3 consecutive results while the other sources are idle -> accepted at 1/cycle; src_ready[0] stays 1, pending[0] never exceeds 1 since the FIFO drains each cycle. With NUM_BUS=1 and 3 sources saturating, src_ready[0] drops to 0 at count 2 and the third push is held, not lost.
4. Flush: 3 FIFOs hold entries, flush=1 with a simultaneous push from source 1 -> next cycle bus_iscast=00, all pending=0, rr_ptr=0; the dropped push never appears.
5. Asynchronous reset pulsed between clock edges while buses are active -> all outputs 0 immediately, before the next rising edge.
6. Fairness check, NUM_SRC=4, NUM_BUS=1, sources 0 and 3 always valid -> grants strictly alternate 0,3,0,3; neither waits more than 1 cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs drained round-robin onto
// NUM_BUS registered broadcast buses, with a synchronous ROB flush.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_BUS    = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ROB_W      = 3,
  parameter int unsigned SRC_W      = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [NUM_SRC-1:0]                       src_valid,
  output logic [NUM_SRC-1:0]                       src_ready,
  input  logic [NUM_SRC*ROB_W-1:0]                 src_robNum,
  input  logic [NUM_SRC*DATA_W-1:0]                src_data,
  output logic [NUM_BUS-1:0]                       bus_iscast,
  output logic [NUM_BUS*ROB_W-1:0]                 bus_robNum,
  output logic [NUM_BUS*DATA_W-1:0]                bus_data,
  output logic [NUM_BUS*SRC_W-1:0]                 bus_src,
  output logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0] pending
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = ROB_W + DATA_W;

  // FIFO storage and bookkeeping; an entry is {robNum, data}
  logic [ENT_W-1:0] mem_q  [NUM_SRC][FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d  [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] head_q [NUM_SRC];
  logic [PTR_W-1:0] head_d [NUM_SRC];
  logic [PTR_W-1:0] tail_q [NUM_SRC];
  logic [PTR_W-1:0] tail_d [NUM_SRC];
  logic [CNT_W-1:0] cnt_q  [NUM_SRC];
  logic [CNT_W-1:0] cnt_d  [NUM_SRC];
  logic [SRC_W-1:0] rr_q;
  logic [SRC_W-1:0] rr_d;

  // Registered bus state
  logic [NUM_BUS-1:0]        iscast_q, iscast_d;
  logic [NUM_BUS*ROB_W-1:0]  rob_q, rob_d;
  logic [NUM_BUS*DATA_W-1:0] data_q, data_d;
  logic [NUM_BUS*SRC_W-1:0]  bsrc_q, bsrc_d;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Readiness and occupancy come straight from the registered counts
  always_comb begin
    src_ready = '0;
    pending   = '0;
    push      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i]                 = (cnt_q[i] < CNT_W'(FIFO_DEPTH));
      pending[i*CNT_W +: CNT_W]    = cnt_q[i];
      push[i]                      = src_valid[i] & src_ready[i];
    end
  end

  // Round-robin scan from rr_q: first NUM_BUS non-empty FIFOs win, k-th to bus k
  always_comb begin : arb_comb
    int unsigned nwin;
    int unsigned s;
    nwin     = 0;
    s        = 0;
    grant    = '0;
    iscast_d = '0;
    rob_d    = '0;
    data_d   = '0;
    bsrc_d   = '0;
    rr_d     = rr_q;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      s = (32'(rr_q) + k) % NUM_SRC;
      if ((cnt_q[s] != '0) && (nwin < NUM_BUS)) begin
        grant[s]                      = 1'b1;
        iscast_d[nwin]                = 1'b1;
        rob_d[nwin*ROB_W +: ROB_W]    = mem_q[s][head_q[s]][ENT_W-1 -: ROB_W];
        data_d[nwin*DATA_W +: DATA_W] = mem_q[s][head_q[s]][DATA_W-1:0];
        bsrc_d[nwin*SRC_W +: SRC_W]   = SRC_W'(s);
        rr_d                          = (s == NUM_SRC - 1) ? '0 : SRC_W'(s + 1);
        nwin                          = nwin + 1;
      end
    end
    if (flush) begin
      grant    = '0;
      iscast_d = '0;
      rob_d    = '0;
      data_d   = '0;
      bsrc_d   = '0;
      rr_d     = '0;
    end
  end

  // FIFO push/pop; flush empties every FIFO and drops same-cycle pushes
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_d[i][tail_q[i]] = {src_robNum[i*ROB_W +: ROB_W], src_data[i*DATA_W +: DATA_W]};
        tail_d[i]           = ptr_inc(tail_q[i]);
      end
      if (grant[i]) begin
        head_d[i] = ptr_inc(head_q[i]);
      end
      if (push[i] && !grant[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (grant[i] && !push[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    if (flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        head_d[i] = '0;
        tail_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end
  end

  // Control state and bus registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q     <= '0;
      iscast_q <= '0;
      rob_q    <= '0;
      data_q   <= '0;
      bsrc_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      iscast_q <= iscast_d;
      rob_q    <= rob_d;
      data_q   <= data_d;
      bsrc_q   <= bsrc_d;
    end
  end

  // Payload storage needs no reset: counts gate every read
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus_iscast = iscast_q;
  assign bus_robNum = rob_q;
  assign bus_data   = data_q;
  assign bus_src    = bsrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: a 2-bus and a 1-bus instance share clock, reset
// and flush, and are checked each cycle against a queue-based model.
module tb_cdb_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 3;

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  logic clock;
  logic reset;
  logic flush;
  logic [NS-1:0]    sv [2];
  logic [NS*RW-1:0] sr [2];
  logic [NS*DW-1:0] sd [2];

  logic [NS-1:0] rdy0, rdy1;
  logic [1:0]    isc0;
  logic [0:0]    isc1;
  logic [5:0]    rob0;
  logic [2:0]    rob1;
  logic [63:0]   dat0;
  logic [31:0]   dat1;
  logic [3:0]    bs0;
  logic [1:0]    bs1;
  logic [7:0]    pend0, pend1;

  cdb_arbiter #(.NUM_SRC(4), .NUM_BUS(2), .DATA_W(32), .ROB_W(3), .SRC_W(2), .FIFO_DEPTH(2)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(sv[0]), .src_ready(rdy0), .src_robNum(sr[0]), .src_data(sd[0]),
    .bus_iscast(isc0), .bus_robNum(rob0), .bus_data(dat0), .bus_src(bs0), .pending(pend0)
  );

  cdb_arbiter #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(32), .ROB_W(3), .SRC_W(2), .FIFO_DEPTH(2)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(sv[1]), .src_ready(rdy1), .src_robNum(sr[1]), .src_data(sd[1]),
    .bus_iscast(isc1), .bus_robNum(rob1), .bus_data(dat1), .bus_src(bs1), .pending(pend1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [87:0] act0, exp0;
  logic [49:0] act1, exp1;
  assign act0 = {isc0, rob0, dat0, bs0, pend0, rdy0};
  assign act1 = {isc1, rob1, dat1, bs1, pend1, rdy1};

  int ntest;
  int nfail;
  int cyc;

  // Model state: queue per (instance, source), rr pointer, expected buses
  ent_t        mq [8][$];
  int unsigned rr [2];
  int unsigned nb [2];
  logic        ev [2][2];
  logic [2:0]  er [2][2];
  logic [31:0] ed [2][2];
  logic [1:0]  es [2][2];

  task automatic build_exp();
    logic [1:0]  v0;
    logic [5:0]  r0;
    logic [63:0] d0;
    logic [3:0]  s0;
    logic [7:0]  p0, p1;
    logic [3:0]  y0, y1;
    for (int k = 0; k < 2; k++) begin
      v0[k]          = ev[0][k];
      r0[k*3 +: 3]   = er[0][k];
      d0[k*32 +: 32] = ed[0][k];
      s0[k*2 +: 2]   = es[0][k];
    end
    for (int s = 0; s < 4; s++) begin
      p0[s*2 +: 2] = 2'(mq[s].size());
      p1[s*2 +: 2] = 2'(mq[4+s].size());
      y0[s]        = (mq[s].size() < 2);
      y1[s]        = (mq[4+s].size() < 2);
    end
    exp0 = {v0, r0, d0, s0, p0, y0};
    exp1 = {ev[1][0], er[1][0], ed[1][0], es[1][0], p1, y1};
  endtask

  task automatic clear_buses();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 2; k++) begin
        ev[j][k] = 1'b0; er[j][k] = '0; ed[j][k] = '0; es[j][k] = '0;
      end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 8; q++) mq[q].delete();
    rr[0] = 0; rr[1] = 0;
    clear_buses();
    build_exp();
  endtask

  // Advance the model by one edge using the currently driven inputs
  task automatic model_step();
    logic acc [4];
    int unsigned nw, last, s;
    ent_t e;
    clear_buses();
    for (int j = 0; j < 2; j++) begin
      if (flush) begin
        for (int q = 0; q < 4; q++) mq[j*4+q].delete();
        rr[j] = 0;
      end else begin
        for (int q = 0; q < 4; q++) acc[q] = sv[j][q] && (mq[j*4+q].size() < 2);
        nw = 0; last = 0;
        for (int unsigned k = 0; k < 4; k++) begin
          s = (rr[j] + k) % 4;
          if (mq[j*4+s].size() > 0 && nw < nb[j]) begin
            e = mq[j*4+s].pop_front();
            ev[j][nw] = 1'b1; er[j][nw] = e.r; ed[j][nw] = e.d; es[j][nw] = 2'(s);
            last = s;
            nw++;
          end
        end
        if (nw > 0) rr[j] = (last + 1) % 4;
        for (int q = 0; q < 4; q++)
          if (acc[q]) begin
            e.r = sr[j][q*3 +: 3];
            e.d = sd[j][q*32 +: 32];
            mq[j*4+q].push_back(e);
          end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    build_exp();
    cyc++;
  endtask

  task automatic drive_idle();
    for (int j = 0; j < 2; j++) begin
      sv[j] = '0; sr[j] = '0; sd[j] = '0;
    end
    flush = 1'b0;
  endtask

  task automatic drive_rand(input int j, input logic [3:0] valid);
    sv[j] = valid;
    sr[j] = 12'($urandom);
    sd[j] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic flush_tick();
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    #3;
    model_reset();
    ntest++;
    if (act0 !== exp0) begin nfail++; $display("FAIL reset dut0 got %h exp %h", act0, exp0); end
    ntest++;
    if (act1 !== exp1) begin nfail++; $display("FAIL reset dut1 got %h exp %h", act1, exp1); end
    ntest++;
    if (rdy0 !== 4'hf || pend0 !== 8'h00 || isc0 !== 2'b00) begin
      nfail++; $display("FAIL reset_const rdy %h pend %h isc %b, want f 00 00", rdy0, pend0, isc0);
    end
    #9;
    reset = 1'b1;
    tick();
    ntest++;
    if (act0 !== exp0) begin nfail++; $display("FAIL reset_idle dut0 got %h exp %h", act0, exp0); end
  endtask

  task automatic test_single_push();
    drive_idle();
    for (int j = 0; j < 2; j++) begin
      sv[j][2] = 1'b1; sr[j][6 +: 3] = 3'd5; sd[j][64 +: 32] = 32'h1234;
    end
    tick();
    drive_idle();
    ntest++;
    if (isc0 !== 2'b00 || pend0 !== 8'h10) begin
      nfail++; $display("FAIL single_edge1 isc %b pend %h, want 00 10", isc0, pend0);
    end
    tick();
    ntest++;
    if (isc0 !== 2'b01 || rob0[2:0] !== 3'd5 || dat0[31:0] !== 32'h1234 || bs0[1:0] !== 2'd2) begin
      nfail++; $display("FAIL single_edge2 isc %b rob %0d data %h src %0d, want 01 5 1234 2",
                        isc0, rob0[2:0], dat0[31:0], bs0[1:0]);
    end
    ntest++;
    if (act1 !== exp1) begin nfail++; $display("FAIL single_edge2 dut1 got %h exp %h", act1, exp1); end
    tick();
    ntest++;
    if (isc0 !== 2'b00 || act0 !== exp0) begin
      nfail++; $display("FAIL single_edge3 dut0 got %h exp %h", act0, exp0);
    end
  endtask

  task automatic test_all_push();
    logic [3:0] want_src;
    flush_tick();
    for (int i = 1; i <= 8; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, (i <= 4) ? 4'hf : 4'h0);
      tick();
      ntest++;
      if (act0 !== exp0) begin nfail++; $display("FAIL all_push dut0 cyc %0d got %h exp %h", cyc, act0, exp0); end
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL all_push dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
      if (i >= 2 && i <= 4) begin
        want_src = (i % 2 == 0) ? 4'b0100 : 4'b1110;
        ntest++;
        if (isc0 !== 2'b11 || bs0 !== want_src) begin
          nfail++; $display("FAIL all_push_grant i=%0d isc %b src %b, want 11 %b", i, isc0, bs0, want_src);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_fifo_full();
    logic seen_full;
    flush_tick();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, (i < 3) ? 4'b0001 : 4'b0000);
      tick();
      ntest++;
      if (act0 !== exp0 || pend0[1:0] > 2'd1 || rdy0[0] !== 1'b1) begin
        nfail++; $display("FAIL fifo_drain dut0 cyc %0d got %h exp %h", cyc, act0, exp0);
      end
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL fifo_drain dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
    end
    seen_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, 4'b0111);
      tick();
      if (rdy1[0] === 1'b0) seen_full = 1'b1;
      ntest++;
      if (act0 !== exp0) begin nfail++; $display("FAIL fifo_sat dut0 cyc %0d got %h exp %h", cyc, act0, exp0); end
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL fifo_sat dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
    end
    ntest++;
    if (seen_full !== 1'b1) begin nfail++; $display("FAIL fifo_sat_ready src_ready[0] never low, want low at count 2"); end
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL fifo_sat_drain dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
    end
  endtask

  task automatic test_flush();
    flush_tick();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, 4'b0111);
      tick();
    end
    ntest++;
    if (pend0 === 8'h00) begin nfail++; $display("FAIL flush_setup pend %h, want nonzero", pend0); end
    for (int j = 0; j < 2; j++) drive_rand(j, 4'b0010);
    flush = 1'b1;
    tick();
    drive_idle();
    ntest++;
    if (isc0 !== 2'b00 || pend0 !== 8'h00 || isc1 !== 1'b0 || pend1 !== 8'h00) begin
      nfail++; $display("FAIL flush_clear isc %b/%b pend %h/%h, want 0 0 00 00", isc0, isc1, pend0, pend1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      ntest++;
      if (isc0 !== 2'b00 || isc1 !== 1'b0 || act0 !== exp0) begin
        nfail++; $display("FAIL flush_dropped cyc %0d got %h exp %h", cyc, act0, exp0);
      end
    end
    for (int j = 0; j < 2; j++) drive_rand(j, 4'b1001);
    tick();
    drive_idle();
    tick();
    ntest++;
    if (isc1 !== 1'b1 || bs1 !== 2'd0 || act1 !== exp1) begin
      nfail++; $display("FAIL flush_rr isc %b src %0d, want 1 0", isc1, bs1);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, 4'hf);
      tick();
    end
    ntest++;
    if (isc0 !== 2'b11 || act0 !== exp0) begin nfail++; $display("FAIL areset_setup got %h exp %h", act0, exp0); end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    ntest++;
    if (act0 !== exp0 || isc0 !== 2'b00 || pend0 !== 8'h00 || rdy0 !== 4'hf || dat0 !== 64'h0) begin
      nfail++; $display("FAIL areset_dut0 got %h exp %h", act0, exp0);
    end
    ntest++;
    if (act1 !== exp1) begin nfail++; $display("FAIL areset_dut1 got %h exp %h", act1, exp1); end
    drive_idle();
    #2;
    reset = 1'b1;
    tick();
    ntest++;
    if (act0 !== exp0) begin nfail++; $display("FAIL areset_after got %h exp %h", act0, exp0); end
  endtask

  task automatic test_fairness();
    logic [1:0] prev;
    flush_tick();
    prev = 2'd3;
    for (int i = 1; i <= 14; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, 4'b1001);
      tick();
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL fair dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
      if (i >= 2) begin
        ntest++;
        if (isc1 !== 1'b1 || bs1 === prev) begin
          nfail++; $display("FAIL fair_alt i=%0d isc %b src %0d prev %0d, want alternation", i, isc1, bs1, prev);
        end
        prev = bs1;
      end
    end
    drive_idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 2; j++) drive_rand(j, 4'($urandom));
      flush = ($urandom_range(0, 31) == 0);
      tick();
      ntest++;
      if (act0 !== exp0) begin nfail++; $display("FAIL random dut0 cyc %0d got %h exp %h", cyc, act0, exp0); end
      ntest++;
      if (act1 !== exp1) begin nfail++; $display("FAIL random dut1 cyc %0d got %h exp %h", cyc, act1, exp1); end
    end
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      ntest++;
      if (act0 !== exp0 || act1 !== exp1) begin
        nfail++; $display("FAIL random_drain cyc %0d got %h/%h exp %h/%h", cyc, act0, act1, exp0, exp1);
      end
    end
  endtask

  initial begin
    ntest = 0;
    nfail = 0;
    cyc   = 0;
    nb[0] = 2;
    nb[1] = 1;
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_single_push();
    test_all_push();
    test_fifo_full();
    test_flush();
    test_async_reset();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
